// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared constants and types for the gray_preproc video front end
//
// Contents:
//   H_ACTIVE_DEF / V_ACTIVE_DEF    default active geometry (640 x 480)
//   COEF_R / COEF_G / COEF_B       luma weights, sum to 256
//   LUMA_SHIFT                     normalising shift for the weighted sum
//   SIDE_W                         width of {frame_start, y, x} side-band
//   vid_state_e                    line-tracking FSM states
//   PIPE_LAT                       input-to-output latency (3 with GRAY_SMOOTH_EN)
// Optional build macro: GRAY_SMOOTH_EN

package vid_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [11:0] COEF_R     = 12'd77;
    localparam logic [11:0] COEF_G     = 12'd150;
    localparam logic [11:0] COEF_B     = 12'd29;
    localparam int          LUMA_SHIFT = 8;

    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int SIDE_W = 1 + Y_W + X_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } vid_state_e;

`ifdef GRAY_SMOOTH_EN
    localparam int PIPE_LAT = 3;
`else
    localparam int PIPE_LAT = 2;
`endif

endpackage

// File: rtl/gray_preproc_luma_pipe.sv
// rtl/gray_preproc_luma_pipe.sv - two-stage RGB444 to 4-bit luma pipeline
//
// Ports:
//   clk, reset        pixel clock, asynchronous active-high reset
//   rgb_i [11:0]      {R, G, B} nibbles
//   valid_i           pixel qualifier
//   side_i            side-band travelling with the pixel
//   luma_o [3:0]      (77R + 150G + 29B) >> 8, forced to 0 when not valid
//   valid_o           valid delayed 2 cycles
//   side_o            side-band of the last valid pixel (held while invalid)

module luma_pipe
    import vid_pkg::*;
#(
    parameter int SW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [11:0]   rgb_i,
    input  logic          valid_i,
    input  logic [SW-1:0] side_i,
    output logic [3:0]    luma_o,
    output logic          valid_o,
    output logic [SW-1:0] side_o
);

    logic [11:0]   prod_r_q;
    logic [11:0]   prod_g_q;
    logic [11:0]   prod_b_q;
    logic          valid1_q;
    logic [SW-1:0] side1_q;

    logic [3:0]    luma_q;
    logic          valid2_q;
    logic [SW-1:0] side2_q;

    logic [11:0]   sum;
    logic [11:0]   sum_shifted;

    // Weights sum to 256, so the full-scale sum is 15*256 = 3840 and fits 12 bits.
    always_comb begin
        sum         = prod_r_q + prod_g_q + prod_b_q;
        sum_shifted = sum >> LUMA_SHIFT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            valid1_q <= 1'b0;
            side1_q  <= '0;
            luma_q   <= '0;
            valid2_q <= 1'b0;
            side2_q  <= '0;
        end else begin
            prod_r_q <= COEF_R * {8'd0, rgb_i[11:8]};
            prod_g_q <= COEF_G * {8'd0, rgb_i[7:4]};
            prod_b_q <= COEF_B * {8'd0, rgb_i[3:0]};
            valid1_q <= valid_i;
            // Side-band only advances with real pixels so coordinates hold during blanking.
            if (valid_i) begin
                side1_q <= side_i;
            end

            valid2_q <= valid1_q;
            luma_q   <= valid1_q ? sum_shifted[3:0] : 4'd0;
            if (valid1_q) begin
                side2_q <= side1_q;
            end
        end
    end

    assign luma_o  = luma_q;
    assign valid_o = valid2_q;
    assign side_o  = side2_q;

endmodule

// File: rtl/gray_preproc.sv
// rtl/gray_preproc.sv - RGB444 to luma front end with coordinate regeneration
//
// Ports:
//   clk, reset          pixel clock, asynchronous active-high reset
//   rgb_in [11:0]       raw pixel {R, G, B}
//   de_in               active-video qualifier
//   vsync_in            frame sync, rising edge starts a frame
//   gray_out [11:0]     {Y, Y, Y}, 0 when de_out is low
//   x_coor [9:0]        column of gray_out (held while de_out is low)
//   y_coor [8:0]        line of gray_out (held while de_out is low)
//   de_out              gray_out valid
//   frame_start         pulse with the first de_out of a frame
//   line_err            sticky: line longer than H_ACTIVE or frame taller than V_ACTIVE
// Optional build macro: GRAY_SMOOTH_EN adds a [1 2 1]/4 horizontal smoother (+1 cycle).

module gray_preproc
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rgb_in,
    input  logic        de_in,
    input  logic        vsync_in,
    output logic [11:0] gray_out,
    output logic [9:0]  x_coor,
    output logic [8:0]  y_coor,
    output logic        de_out,
    output logic        frame_start,
    output logic        line_err
);

    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);

    // ---------------- input-side line tracking ----------------
    vid_state_e     state_q, state_d;
    logic           vsync_q;
    logic           de_prev_q;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           y_full_q, y_full_d;
    logic           first_pend_q, first_pend_d;
    logic           line_err_q, line_err_d;

    logic           vs_rise;
    logic           de_rise;
    logic           pix_act;
    logic           pix_first;

    always_comb begin
        vs_rise      = vsync_in & ~vsync_q;
        de_rise      = de_in & ~de_prev_q;
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        y_full_d     = y_full_q;
        first_pend_d = first_pend_q;
        line_err_d   = line_err_q;
        pix_act      = 1'b0;
        pix_first    = 1'b0;

        if (vs_rise) begin
            // A new frame overrides everything, including a de_in edge in the same cycle.
            state_d      = BLANK;
            y_d          = '0;
            y_full_d     = 1'b0;
            first_pend_d = 1'b1;
        end else begin
            case (state_q)
                BLANK: begin
                    if (de_rise) begin
                        state_d      = ACTIVE;
                        pix_act      = 1'b1;
                        pix_first    = first_pend_q;
                        first_pend_d = 1'b0;
                        x_d          = '0;
                        // The last legal line already closed; this one is surplus.
                        if (y_full_q) begin
                            line_err_d = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (!de_in) begin
                        state_d = BLANK;
                        // A full frame ends at Y_MAX; only a further line is an error.
                        if (y_q == Y_MAX) begin
                            y_full_d = 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        pix_act = 1'b1;
                        if (x_q == X_MAX) begin
                            line_err_d = 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            de_prev_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            y_full_q     <= 1'b0;
            first_pend_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_in;
            de_prev_q    <= de_in;
            x_q          <= x_d;
            y_q          <= y_d;
            y_full_q     <= y_full_d;
            first_pend_q <= first_pend_d;
            line_err_q   <= line_err_d;
        end
    end

    // ---------------- luma pipeline ----------------
    // x_d is the column of the pixel being accepted this cycle; y_q its line.
    logic [SIDE_W-1:0] pix_side;
    logic [3:0]        lp_luma;
    logic              lp_valid;
    logic [SIDE_W-1:0] lp_side;

    assign pix_side = {pix_first, y_q, x_d};

    luma_pipe #(
        .SW(SIDE_W)
    ) u_luma (
        .clk     (clk),
        .reset   (reset),
        .rgb_i   (rgb_in),
        .valid_i (pix_act),
        .side_i  (pix_side),
        .luma_o  (lp_luma),
        .valid_o (lp_valid),
        .side_o  (lp_side)
    );

    logic [3:0]        out_luma;
    logic              out_valid;
    logic [SIDE_W-1:0] out_side;

`ifdef GRAY_SMOOTH_EN
    // cur_* is pixel n, prev_* pixel n-1, and the luma pipe output is pixel n+1.
    // Consecutive valid pixels always belong to the same line, because a new
    // line can only start on a de_in rising edge after at least one gap cycle.
    logic [3:0]        cur_y_q, prev_y_q, sm_y_q;
    logic              cur_v_q, prev_v_q, sm_v_q;
    logic [SIDE_W-1:0] cur_side_q, sm_side_q;
    logic [3:0]        left_y, right_y;
    logic [5:0]        acc;

    always_comb begin
        left_y  = prev_v_q ? prev_y_q : cur_y_q;
        right_y = lp_valid ? lp_luma : cur_y_q;
        acc     = {2'b00, left_y} + {1'b0, cur_y_q, 1'b0} + {2'b00, right_y};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_y_q    <= '0;
            cur_v_q    <= 1'b0;
            cur_side_q <= '0;
            prev_y_q   <= '0;
            prev_v_q   <= 1'b0;
            sm_y_q     <= '0;
            sm_v_q     <= 1'b0;
            sm_side_q  <= '0;
        end else begin
            cur_y_q    <= lp_luma;
            cur_v_q    <= lp_valid;
            cur_side_q <= lp_side;
            prev_y_q   <= cur_y_q;
            prev_v_q   <= cur_v_q;
            sm_v_q     <= cur_v_q;
            sm_y_q     <= cur_v_q ? acc[5:2] : 4'd0;
            if (cur_v_q) begin
                sm_side_q <= cur_side_q;
            end
        end
    end

    assign out_luma  = sm_y_q;
    assign out_valid = sm_v_q;
    assign out_side  = sm_side_q;
`else
    assign out_luma  = lp_luma;
    assign out_valid = lp_valid;
    assign out_side  = lp_side;
`endif

    assign gray_out    = {out_luma, out_luma, out_luma};
    assign de_out      = out_valid;
    assign x_coor      = out_side[X_W-1:0];
    assign y_coor      = out_side[X_W+Y_W-1:X_W];
    // The side-band holds while idle, so the start flag must be qualified.
    assign frame_start = out_side[SIDE_W-1] & out_valid;
    assign line_err    = line_err_q;

endmodule

// File: tb/tb_gray_preproc.sv
// tb/tb_gray_preproc.sv - randomized self-checking bench for gray_preproc

module tb_gray_preproc;

    localparam int H = 640;
    localparam int V = 480;
`ifdef GRAY_SMOOTH_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int DEPTH = 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] rgb_in = '0;
    logic        de_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [11:0] gray_out;
    logic [9:0]  x_coor;
    logic [8:0]  y_coor;
    logic        de_out;
    logic        frame_start;
    logic        line_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gray_preproc #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk         (clk),
        .reset       (reset),
        .rgb_in      (rgb_in),
        .de_in       (de_in),
        .vsync_in    (vsync_in),
        .gray_out    (gray_out),
        .x_coor      (x_coor),
        .y_coor      (y_coor),
        .de_out      (de_out),
        .frame_start (frame_start),
        .line_err    (line_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed output word per cycle: {de, fs, gray[11:0], x[9:0], y[8:0]}
    logic [32:0] obs [DEPTH];
    always @(negedge clk) obs[cyc % DEPTH] = {de_out, frame_start, gray_out, x_coor, y_coor};

    // Reference: per accepted-input cycle, what the pixel should become.
    bit mv  [DEPTH];
    bit mfs [DEPTH];
    int my  [DEPTH];
    int mx  [DEPTH];
    int mln [DEPTH];

    bit m_framed, m_inline, m_fspend, m_over, m_err, m_pde, m_pvs;
    int m_col, m_line, m_hx, m_hy;

    function automatic int luma(input logic [11:0] rgb);
        int r, g, b;
        r = int'(rgb[11:8]);
        g = int'(rgb[7:4]);
        b = int'(rgb[3:0]);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    function automatic logic [32:0] exp_word(input int c);
        int p, g;
        logic [3:0] y4;
        p = (c - LAT) % DEPTH;
`ifdef GRAY_SMOOTH_EN
        begin
            int pl, pr, l, r;
            pl = (p + DEPTH - 1) % DEPTH;
            pr = (p + 1) % DEPTH;
            l = mv[pl] ? my[pl] : my[p];
            r = mv[pr] ? my[pr] : my[p];
            g = (l + 2 * my[p] + r) / 4;
        end
`else
        g = my[p];
`endif
        if (!mv[p]) g = 0;
        y4 = 4'(g);
        return {mv[p], mfs[p] & mv[p], y4, y4, y4, 10'(mx[p]), 9'(mln[p])};
    endfunction

    task automatic step(input logic [11:0] rgb, input logic de, input logic vs);
        int p;
        bit v, f, vr, dr;
        rgb_in = rgb;
        de_in = de;
        vsync_in = vs;
        p = cyc % DEPTH;
        vr = vs && !m_pvs;
        dr = de && !m_pde;
        v = 0;
        f = 0;
        if (vr) begin
            m_framed = 1; m_inline = 0; m_line = 0; m_fspend = 1; m_over = 0;
        end else if (m_framed) begin
            if (!m_inline) begin
                if (dr) begin
                    m_inline = 1; m_col = 0; v = 1; f = m_fspend; m_fspend = 0;
                    if (m_over) m_err = 1;
                end
            end else if (de) begin
                if (m_col == H - 1) m_err = 1;
                else m_col = m_col + 1;
                v = 1;
            end else begin
                m_inline = 0;
                if (m_line == V - 1) m_over = 1;
                else m_line = m_line + 1;
            end
        end
        m_pvs = vs;
        m_pde = de;
        if (v) begin
            m_hx = m_col;
            m_hy = m_line;
        end
        mv[p] = v; mfs[p] = f; my[p] = v ? luma(rgb) : 0; mx[p] = m_hx; mln[p] = m_hy;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rgb_in = '0; de_in = 1'b0; vsync_in = 1'b0;
        m_framed = 0; m_inline = 0; m_fspend = 0; m_over = 0; m_err = 0;
        m_pde = 0; m_pvs = 0; m_col = 0; m_line = 0; m_hx = 0; m_hy = 0;
        for (int i = 0; i < 4; i++) begin
            int p;
            p = cyc % DEPTH;
            mv[p] = 0; mfs[p] = 0; my[p] = 0; mx[p] = 0; mln[p] = 0;
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic run_line(input int n, input int gap);
        for (int i = 0; i < n; i++) step(12'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < gap; i++) step(12'($urandom), 1'b0, 1'b0);
    endtask

    task automatic vsync_pulse();
        step(12'h000, 1'b0, 1'b1);
        step(12'h000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({gray_out, x_coor, y_coor, de_out, frame_start, line_err} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got gray=%h x=%0d y=%0d de=%b fs=%b err=%b expected all zero",
                     gray_out, x_coor, y_coor, de_out, frame_start, line_err);
        end
    endtask

    task automatic test_no_vsync();
        int t0, n_de;
        t0 = cyc;
        run_line(H, 20);
        run_line(H, 20);
        n_de = 0;
        for (int c = t0 + LAT; c < cyc; c++) begin
            vectors++;
            if (obs[c % DEPTH] !== exp_word(c)) begin
                miscompares++;
                $display("FAIL no_vsync_stream cycle %0d got %h expected %h", c, obs[c % DEPTH], exp_word(c));
            end
            if (obs[c % DEPTH][32] || obs[c % DEPTH][31]) n_de++;
        end
        vectors++;
        if (n_de !== 0) begin
            miscompares++;
            $display("FAIL no_vsync_de_count got %0d expected 0", n_de);
        end
    endtask

    task automatic test_colors();
        int t0;
        logic [32:0] w;
        logic [11:0] pix [5];
        logic [11:0] exp_g [5];
        int k;
        pix[0] = 12'hFFF; pix[1] = 12'h000; pix[2] = 12'hF00; pix[3] = 12'h0F0; pix[4] = 12'h00F;
        exp_g[0] = 12'hFFF; exp_g[1] = 12'h000; exp_g[2] = 12'h444; exp_g[3] = 12'h888; exp_g[4] = 12'h111;
        t0 = cyc;
        vsync_pulse();
        for (int i = 0; i < 5; i++) step(pix[i], 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(12'h000, 1'b0, 1'b0);
        k = 0;
        for (int c = t0 + LAT; c < cyc; c++) begin
            w = obs[c % DEPTH];
            vectors++;
            if (w !== exp_word(c)) begin
                miscompares++;
                $display("FAIL colors_stream cycle %0d got %h expected %h", c, w, exp_word(c));
            end
            if (w[32]) begin
                vectors++;
                if (k < 5 && (w[18:9] !== 10'(k) || w[8:0] !== 9'd0 || w[31] !== (k == 0))) begin
                    miscompares++;
                    $display("FAIL colors_coord pixel %0d got x=%0d y=%0d fs=%b expected x=%0d y=0 fs=%b",
                             k, w[18:9], w[8:0], w[31], k, (k == 0));
                end
`ifndef GRAY_SMOOTH_EN
                vectors++;
                if (k < 5 && w[30:19] !== exp_g[k]) begin
                    miscompares++;
                    $display("FAIL colors_gray pixel %0d got %h expected %h", k, w[30:19], exp_g[k]);
                end
`endif
                k++;
            end
        end
        vectors++;
        if (k !== 5) begin
            miscompares++;
            $display("FAIL colors_count got %0d expected 5", k);
        end
    endtask

    task automatic test_three_lines();
        int t0;
        int cnt [3];
        logic [32:0] w;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        t0 = cyc;
        vsync_pulse();
        for (int l = 0; l < 3; l++) run_line(H, 16);
        for (int c = t0 + LAT; c < cyc; c++) begin
            w = obs[c % DEPTH];
            vectors++;
            if (w !== exp_word(c)) begin
                miscompares++;
                $display("FAIL three_lines_stream cycle %0d got %h expected %h", c, w, exp_word(c));
            end
            if (w[32] && w[8:0] < 9'd3) cnt[w[8:0]]++;
        end
        for (int l = 0; l < 3; l++) begin
            vectors++;
            if (cnt[l] !== H) begin
                miscompares++;
                $display("FAIL three_lines_de_count line %0d got %0d expected %0d", l, cnt[l], H);
            end
        end
        vectors++;
        if (line_err !== 1'b0) begin
            miscompares++;
            $display("FAIL three_lines_line_err got %b expected 0", line_err);
        end
    endtask

    task automatic test_long_line();
        int t0, n_sat;
        logic [32:0] w;
        t0 = cyc;
        vsync_pulse();
        run_line(H + 5, 16);
        n_sat = 0;
        for (int c = t0 + LAT; c < cyc; c++) begin
            w = obs[c % DEPTH];
            vectors++;
            if (w !== exp_word(c)) begin
                miscompares++;
                $display("FAIL long_line_stream cycle %0d got %h expected %h", c, w, exp_word(c));
            end
            if (w[32] && w[18:9] == 10'd639) n_sat++;
        end
        vectors++;
        if (n_sat !== 6) begin
            miscompares++;
            $display("FAIL long_line_sat_count got %0d expected 6", n_sat);
        end
        run_line(0, 30);
        vectors++;
        if (line_err !== 1'b1) begin
            miscompares++;
            $display("FAIL long_line_err_sticky got %b expected 1", line_err);
        end
    endtask

    task automatic test_vsync_abort();
        int t0, n_y7, n_fs;
        logic [32:0] w;
        t0 = cyc;
        vsync_pulse();
        for (int l = 0; l < 7; l++) run_line(12, 4);
        for (int i = 0; i < 100; i++) step(12'($urandom), 1'b1, 1'b0);
        step(12'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(12'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(12'($urandom), 1'b0, 1'b0);
        run_line(10, 8);
        n_y7 = 0;
        n_fs = 0;
        for (int c = t0 + LAT; c < cyc; c++) begin
            w = obs[c % DEPTH];
            vectors++;
            if (w !== exp_word(c)) begin
                miscompares++;
                $display("FAIL abort_stream cycle %0d got %h expected %h", c, w, exp_word(c));
            end
            if (w[32] && w[8:0] == 9'd7) n_y7++;
            if (w[31]) n_fs++;
        end
        vectors++;
        if (n_y7 !== 100) begin
            miscompares++;
            $display("FAIL abort_line7_pixels got %0d expected 100", n_y7);
        end
        vectors++;
        if (n_fs !== 2) begin
            miscompares++;
            $display("FAIL abort_frame_start_count got %0d expected 2", n_fs);
        end
    endtask

    task automatic test_random();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                step(12'($urandom), 1'($urandom_range(0, 1)), 1'b1);
                step(12'($urandom), 1'b0, 1'b0);
            end else begin
                bit d;
                int len;
                d = 1'($urandom_range(0, 1));
                len = $urandom_range(1, 12);
                for (int j = 0; j < len; j++) step(12'($urandom), d, 1'b0);
            end
        end
        run_line(0, 8);
        for (int c = t0 + LAT; c < cyc; c++) begin
            vectors++;
            if (obs[c % DEPTH] !== exp_word(c)) begin
                miscompares++;
                $display("FAIL random_stream cycle %0d got %h expected %h", c, obs[c % DEPTH], exp_word(c));
            end
        end
    endtask

`ifdef GRAY_SMOOTH_EN
    task automatic test_smooth();
        int t0, k;
        logic [32:0] w;
        logic [11:0] exp_g [6];
        exp_g[0] = 12'h000; exp_g[1] = 12'h333; exp_g[2] = 12'h777;
        exp_g[3] = 12'h333; exp_g[4] = 12'h000; exp_g[5] = 12'hFFF;
        t0 = cyc;
        vsync_pulse();
        step(12'h000, 1'b1, 1'b0);
        step(12'h000, 1'b1, 1'b0);
        step(12'hFFF, 1'b1, 1'b0);
        step(12'h000, 1'b1, 1'b0);
        step(12'h000, 1'b1, 1'b0);
        run_line(0, 4);
        step(12'hFFF, 1'b1, 1'b0);
        run_line(0, 8);
        k = 0;
        for (int c = t0 + LAT; c < cyc; c++) begin
            w = obs[c % DEPTH];
            if (w[32]) begin
                vectors++;
                if (k < 6 && w[30:19] !== exp_g[k]) begin
                    miscompares++;
                    $display("FAIL smooth_gray pixel %0d got %h expected %h", k, w[30:19], exp_g[k]);
                end
                k++;
            end
        end
        vectors++;
        if (k !== 6) begin
            miscompares++;
            $display("FAIL smooth_count got %0d expected 6", k);
        end
    endtask
`endif

    task automatic test_final_reset();
        do_reset();
        vectors++;
        if (line_err !== 1'b0 || de_out !== 1'b0 || x_coor !== 10'd0 || y_coor !== 9'd0) begin
            miscompares++;
            $display("FAIL final_reset got err=%b de=%b x=%0d y=%0d expected 0 0 0 0",
                     line_err, de_out, x_coor, y_coor);
        end
    endtask

    initial begin
        test_reset();
        test_no_vsync();
        test_colors();
        test_three_lines();
        test_long_line();
        test_vsync_abort();
        test_random();
`ifdef GRAY_SMOOTH_EN
        test_smooth();
`endif
        test_final_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_preproc.md
Name: gray_preproc

Overview:
- Upstream stage of the Sobel/Scharr edge filter.
- Takes raw RGB444 pixels with de/vsync from the capture/timing path.
- Converts each pixel to 4-bit luma through a pipeline and regenerates pixel coordinates from the sync signals.
- Delivers gray_out, x_coor, y_coor and de_out, mutually aligned, to the filter's gray_in/x_coor/y_coor/de inputs.

Parameters:
- H_ACTIVE, 640: active pixels per line; x_coor saturates at H_ACTIVE-1.
- V_ACTIVE, 480: active lines per frame; y_coor saturates at V_ACTIVE-1.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  reset, asynchronous, active-high.
- rgb_in  in  12  pixel {R[11:8], G[7:4], B[3:0]}.
- de_in  in  1  active-video qualifier.
- vsync_in  in  1  frame sync, active-high; its rising edge marks a new frame.
- gray_out  out  12  luma replicated {Y,Y,Y}.
- x_coor  out  10  column of gray_out.
- y_coor  out  9  line of gray_out.
- de_out  out  1  gray_out valid.
- frame_start  out  1  one-cycle pulse coincident with the first de_out of a frame.
- line_err  out  1  sticky flag: a line exceeded H_ACTIVE pixels or a frame exceeded V_ACTIVE lines.

Behaviour:
- Reset values: all outputs 0, x_coor=0, y_coor=0, FSM=IDLE, pipeline valid bits cleared.
- Reset asserted mid-frame behaves identically: the block returns to IDLE and waits for the next vsync rising edge.
- FSM states: IDLE, BLANK, ACTIVE.
  - IDLE -> BLANK on the vsync_in rising edge (edge detected with one registered copy of vsync_in).
  - BLANK -> ACTIVE on de_in rising edge (de_in=1 with previous de_in=0).
  - ACTIVE -> BLANK when de_in falls.
  - A vsync rising edge in any non-IDLE state forces BLANK and y=0, and aborts any line in progress.
  - A line is only ever entered on a de_in rising edge, so de_in already high on entry yields no partial line.
- Coordinate counters (input side):
  - x=0 on the first ACTIVE cycle; x increments each ACTIVE cycle and saturates at H_ACTIVE-1.
  - Saturation sets line_err.
  - On ACTIVE->BLANK, y increments, saturating at V_ACTIVE-1 (an attempt beyond that sets line_err).
  - vsync rising edge clears y to 0.
  - Simultaneous de_in fall and vsync rise: vsync wins, y=0.
- Luma: Y = (77*R + 150*G + 29*B) >> 8.
  - Coefficients sum to 256, so white (15,15,15) gives 3840>>8 = 15.
  - Products are unsigned, 12 bits each; the sum fits in 12 bits.
  - Stage 1 registers the three products; stage 2 registers the sum and shift.
- Latency:
  - 2 cycles from rgb_in/de_in to gray_out/de_out.
  - x/y/frame_start are delayed through the same pipeline; de_out = (FSM==ACTIVE) delayed 2 cycles.
  - No throughput loss: one pixel per cycle.
- When de_out=0: gray_out=0; x_coor/y_coor hold their last values.
- line_err clears only on reset.

Optional Feature:
- Macro: GRAY_SMOOTH_EN.
- When defined: a 3-tap horizontal [1 2 1]/4 smoother follows the luma stage.
  - Output pixel n = (Y[n-1] + 2*Y[n] + Y[n+1]) >> 2, using a 6-bit intermediate.
  - Left edge: Y[n-1] is replaced by Y[n]. Right edge (next cycle not valid, or vsync abort): Y[n+1] is replaced by Y[n].
  - Adds 1 cycle; total latency 3.
  - de/x/y/frame_start are delayed by 3 cycles; the de_out pattern is unchanged, only shifted.
- When undefined: the smoother stage is absent and latency is 2.

Decomposition:
- Package vid_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults.
  - Luma coefficients (77, 150, 29) and shift (8).
  - FSM state enum {IDLE, BLANK, ACTIVE}.
  - Pipeline latency constant (2, or 3 under GRAY_SMOOTH_EN).
- One natural sub-module, luma_pipe: two-stage RGB444->Y arithmetic with a valid/side-band passthrough.
- The FSM, counters and smoother live in the top module.

Test Plan:
- Reset, then 640-pixel lines before any vsync -> de_out stays 0, frame_start never pulses.
- vsync pulse, then a line of rgb_in=12'hFFF, 12'h000, 12'hF00, 12'h0F0, 12'h00F -> 2 cycles later gray_out=FFF, 000, 444, 888, 111 with x_coor 0..4, y_coor=0, frame_start high only on the first.
- Three 640-pixel lines separated by blanking -> y_coor 0, 1, 2; x_coor 0..639 per line; de_out exactly 640 cycles per line; line_err=0.
- 645-pixel line -> x_coor sticks at 639 for the last 6 pixels; line_err=1 until reset.
- vsync rising mid-line at x=100, y=7 -> de_out drops after the pipeline drains, no pixels until the next de_in rise; the next line has y_coor=0.
- GRAY_SMOOTH_EN with a line of luma 0, 0, 15, 0, 0 -> outputs 0, 3, 7, 3, 0 at latency 3; a single-pixel line of luma 15 -> 15 (edge replication).
